// File: rtl/seq_decoder.sv
// seq_decoder: registered N-to-2^N one-hot decoder with enable gating and a
// built-in scan sequencer that steps the select through every output with a
// programmable dwell time.
//
// Optional build macro: ONESHOT_SCAN_EN
//   defined   -> a scan makes a single pass and parks in HOLD on the last output
//   undefined -> a scan wraps continuously, pulsing scan_done on every wrap
module seq_decoder #(
    parameter int ADDR_W  = 2,
    parameter int DWELL_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clr,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     scan_start,
    input  logic                     scan_stop,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [(1<<ADDR_W)-1:0]   out,
    output logic [ADDR_W-1:0]        sel,
    output logic                     busy,
    output logic                     scan_done
);

    localparam int NOUT = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SEL_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    sel_reg,   sel_next;
    logic [DWELL_W-1:0]   dwell_reg, dwell_next;
    logic [DWELL_W-1:0]   cnt_reg,   cnt_next;
    logic                 done_reg,  done_next;
    logic                 out_en;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            dwell_reg <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            dwell_reg <= dwell_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic; commands are prioritised clr > scan_stop > scan_start > load.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        dwell_next = dwell_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;

        if (clr) begin
            state_next = IDLE;
            sel_next   = '0;
            cnt_next   = '0;
        end else if (scan_stop) begin
            // Only meaningful while scanning; elsewhere it simply masks
            // the lower-priority commands for this cycle.
            if (state_reg == SCAN) begin
                state_next = HOLD;
                cnt_next   = '0;
            end
        end else if (scan_start) begin
            // Same action from IDLE, HOLD, or as a restart from SCAN.
            state_next = SCAN;
            sel_next   = '0;
            cnt_next   = '0;
            dwell_next = dwell;
        end else begin
            case (state_reg)
                IDLE, HOLD: begin
                    if (load) begin
                        state_next = HOLD;
                        sel_next   = addr;
                    end
                end
                SCAN: begin
                    // enable low pauses the scan: cnt and sel both freeze.
                    if (enable) begin
                        if (cnt_reg == dwell_reg) begin
                            cnt_next = '0;
                            if (sel_reg == SEL_LAST) begin
                                done_next = 1'b1;
`ifdef ONESHOT_SCAN_EN
                                // Single pass: park on the last output.
                                state_next = HOLD;
`else
                                sel_next = '0;
`endif
                            end else begin
                                sel_next = sel_reg + 1'b1;
                            end
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    sel_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are gated by enable in the same cycle; state is untouched.
    assign out_en    = (state_reg != IDLE) && enable;
    assign sel       = sel_reg;
    assign busy      = (state_reg == SCAN);
    assign scan_done = done_reg;

    // One comparator per output line forms the one-hot decode.
    genvar gi;
    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_dec
            assign out[gi] = out_en && (sel_reg == ADDR_W'(gi));
        end
    endgenerate

endmodule
